// File: rtl/operand_forwarder_pkg.sv
// Shared LC-3b forwarding types: the in-flight tag record and the
// forwarding-select encoding used between decode and the EX input muxes.
package lc3b_types;

    typedef logic [15:0] lc3b_word;

    // Destination field is sized for the widest register file we expect;
    // narrower register addresses are zero-extended on the way in.
    localparam int FWD_DEST_W = 8;

    // fwd_sel value meaning "operand comes from the register file".
    localparam int FWD_SEL_RF = 0;

    typedef struct packed {
        logic                  valid;
        logic [FWD_DEST_W-1:0] dest;
        logic                  is_load;
    } fwd_tag_t;

endpackage

// File: rtl/operand_forwarder_tag_pipe.sv
// DEPTH-entry shift register of in-flight destination tags. Stage 0 is the
// youngest post-issue stage; the oldest entry falls off the end on advance.
module fwd_tag_pipe
    import lc3b_types::*;
#(
    parameter int DEPTH  = 3,
    parameter int REG_AW = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    advance,
    input  logic                    flush,
    input  logic                    iss_valid,
    input  logic                    iss_we,
    input  logic                    iss_load,
    input  logic [REG_AW-1:0]       iss_dest,
    input  logic                    stall,
    output fwd_tag_t [DEPTH-1:0]    tags
);

    fwd_tag_t [DEPTH-1:0] tags_r;
    fwd_tag_t             new_tag_s;

    // Build the tag entering stage 0; a stalled or non-writing issue is a bubble.
    always_comb begin
        new_tag_s         = '0;
        new_tag_s.valid   = iss_valid & iss_we & ~stall;
        new_tag_s.dest    = FWD_DEST_W'(iss_dest);
        new_tag_s.is_load = iss_load;
    end

    // Tag shift register: reset and flush kill everything, advance shifts.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tags_r <= '0;
        end else if (flush) begin
            tags_r <= '0;
        end else if (advance) begin
            tags_r[0] <= new_tag_s;
            for (int k = 1; k < DEPTH; k++) begin
                tags_r[k] <= tags_r[k-1];
            end
        end else begin
            tags_r <= tags_r;
        end
    end

    assign tags = tags_r;

endmodule

// File: rtl/operand_forwarder.sv
// Operand forwarding unit: per source picks the youngest in-flight producer
// (or the register file), raises a load-use stall when that producer's data
// is not ready yet, and counts stall cycles with a saturating counter.
module operand_forwarder
    import lc3b_types::*;
#(
    parameter int WIDTH   = 16,
    parameter int NUM_SRC = 2,
    parameter int DEPTH   = 3,
    parameter int REG_AW  = 3,
    parameter int CNT_W   = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                advance,
    input  logic                                flush,
    input  logic                                iss_valid,
    input  logic                                iss_we,
    input  logic                                iss_load,
    input  logic [REG_AW-1:0]                   iss_dest,
    input  logic [NUM_SRC*REG_AW-1:0]           src_addr,
    input  logic [NUM_SRC-1:0]                  src_used,
    input  logic [NUM_SRC*WIDTH-1:0]            rf_data,
    input  logic [DEPTH*WIDTH-1:0]              stage_result,
    input  logic [DEPTH-1:0]                    stage_ready,
    output logic [NUM_SRC*WIDTH-1:0]            opnd,
    output logic [NUM_SRC*$clog2(DEPTH+1)-1:0]  fwd_sel,
    output logic                                stall,
    output logic [CNT_W-1:0]                    stall_count
);

    localparam int SEL_W = $clog2(DEPTH+1);

    fwd_tag_t [DEPTH-1:0] tags_s;
    logic [NUM_SRC-1:0]   src_stall_s;
    logic [CNT_W-1:0]     stall_count_r;

    fwd_tag_pipe #(
        .DEPTH  (DEPTH),
        .REG_AW (REG_AW)
    ) u_tag_pipe (
        .clk       (clk),
        .rst_n     (rst_n),
        .advance   (advance),
        .flush     (flush),
        .iss_valid (iss_valid),
        .iss_we    (iss_we),
        .iss_load  (iss_load),
        .iss_dest  (iss_dest),
        .stall     (stall),
        .tags      (tags_s)
    );

    for (genvar s = 0; s < NUM_SRC; s++) begin : g_src
        logic [FWD_DEST_W-1:0] addr_s;
        logic [SEL_W-1:0]      sel_s;
        logic                  hit_ready_s;
        logic [WIDTH-1:0]      hit_data_s;
        logic                  hit_s;

        assign addr_s = FWD_DEST_W'(src_addr[s*REG_AW +: REG_AW]);

        // Walk oldest to youngest so the youngest match is written last and
        // wins; a younger unready producer therefore masks an older ready one.
        always_comb begin
            sel_s       = SEL_W'(FWD_SEL_RF);
            hit_ready_s = 1'b0;
            hit_data_s  = '0;
            for (int k = DEPTH - 1; k >= 0; k--) begin
                logic m;
                m           = src_used[s] && tags_s[k].valid && (tags_s[k].dest == addr_s);
                sel_s       = m ? SEL_W'(k + 1) : sel_s;
                hit_ready_s = m ? stage_ready[k] : hit_ready_s;
                hit_data_s  = m ? stage_result[k*WIDTH +: WIDTH] : hit_data_s;
            end
        end

        assign hit_s          = (sel_s != SEL_W'(FWD_SEL_RF));
        assign src_stall_s[s] = hit_s && !hit_ready_s;
        assign opnd[s*WIDTH +: WIDTH]    = (hit_s && hit_ready_s) ? hit_data_s
                                                                  : rf_data[s*WIDTH +: WIDTH];
        assign fwd_sel[s*SEL_W +: SEL_W] = sel_s;
    end

    assign stall = |src_stall_s;

    // Saturating stall-cycle counter; sticks at all-ones instead of wrapping.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_count_r <= '0;
        end else if (stall && (stall_count_r != {CNT_W{1'b1}})) begin
            stall_count_r <= stall_count_r + CNT_W'(1);
        end else begin
            stall_count_r <= stall_count_r;
        end
    end

    assign stall_count = stall_count_r;

endmodule
